// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
// Shares the single register-file write port (we3/wa3/wd3) between two
// writeback sources:
//   A - execute/ALU writeback, direct path, wins by default
//   B - load/memory writeback, buffered in a small FIFO, with a starvation
//       counter that forces B through after STARVE_MAX unserved cycles or
//       when the FIFO is full.
// Write-port outputs are registered (one cycle from accept/pop to we3).
// Writes to X31 (XZR) complete their handshake/pop but never raise we3.
//
// Optional build macro REGARB_PENDMASK_EN adds the pend_mask output: one bit
// per architectural register that is still in flight (queued in the B FIFO
// or being written this cycle). Bit 31 is always 0.
module regfile_wr_arbiter #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          a_valid,
  output logic                          a_ready,
  input  logic [ADDR_W-1:0]             a_addr,
  input  logic [DATA_W-1:0]             a_data,
  input  logic                          b_valid,
  output logic                          b_ready,
  input  logic [ADDR_W-1:0]             b_addr,
  input  logic [DATA_W-1:0]             b_data,
  output logic                          we3,
  output logic [ADDR_W-1:0]             wa3,
  output logic [DATA_W-1:0]             wd3,
  output logic [$clog2(FIFO_DEPTH):0]   b_count
`ifdef REGARB_PENDMASK_EN
  ,
  output logic [31:0]                   pend_mask
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [STV_W-1:0]  STV_MAX  = STV_W'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] XZR      = ADDR_W'(31);

  // Saturating increment for the starvation counter.
  function automatic logic [STV_W-1:0] sat_inc(input logic [STV_W-1:0] v);
    if (v >= STV_MAX) begin
      return STV_MAX;
    end
    return v + STV_W'(1);
  endfunction

  // FIFO storage (data path, not reset) and control state
  logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [STV_W-1:0]  starve_cnt;

  logic              fifo_nonempty;
  logic              fifo_full;
  logic              force_b;
  logic              push;
  logic              pop;
  logic              issue_a;

  // Stage p0: arbitration result feeding the output register
  logic              issue_vld_p0;
  logic [ADDR_W-1:0] issue_addr_p0;
  logic [DATA_W-1:0] issue_data_p0;

  assign fifo_nonempty = (b_count != '0);
  assign fifo_full     = (b_count == FULL_CNT);

  // B is forced once it has waited long enough or the buffer is full.
  assign force_b = fifo_nonempty && ((starve_cnt >= STV_MAX) || fifo_full);
  assign a_ready = !force_b;

  // Push is judged on the registered count only: a same-cycle pop does not
  // open a slot, keeping b_ready free of any path from the arbiter.
  assign b_ready = !fifo_full;
  assign push    = b_valid && b_ready;

  assign issue_a = a_valid && a_ready;
  assign pop     = !issue_a && fifo_nonempty;

  // Select the write issued this cycle: A wins unless B is forced.
  always_comb begin
    issue_vld_p0  = 1'b0;
    issue_addr_p0 = addr_mem[rd_ptr];
    issue_data_p0 = data_mem[rd_ptr];
    if (issue_a) begin
      issue_vld_p0  = 1'b1;
      issue_addr_p0 = a_addr;
      issue_data_p0 = a_data;
    end else if (pop) begin
      issue_vld_p0 = 1'b1;
    end
  end

  // FIFO entry storage: written at the tail on an accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= b_addr;
      data_mem[wr_ptr] <= b_data;
    end
  end

  // FIFO pointers and occupancy; reset flushes all queued entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      b_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   b_count <= b_count + CNT_W'(1);
        2'b01:   b_count <= b_count - CNT_W'(1);
        default: b_count <= b_count;
      endcase
    end
  end

  // Starvation counter: counts cycles the FIFO head waits behind A.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (pop || !fifo_nonempty) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= sat_inc(starve_cnt);
    end
  end

  // Stage p1: registered write port; XZR writes are issued with we3 low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
    end else if (issue_vld_p0) begin
      we3 <= (issue_addr_p0 != XZR);
      wa3 <= issue_addr_p0;
      wd3 <= issue_data_p0;
    end else begin
      we3 <= 1'b0;
    end
  end

`ifdef REGARB_PENDMASK_EN
  // In-flight register mask: every live FIFO entry plus the write on the port.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (CNT_W'(i) < b_count) begin
        pend_mask[addr_mem[rd_ptr + PTR_W'(i)]] = 1'b1;
      end
    end
    if (we3) begin
      pend_mask[wa3] = 1'b1;
    end
    pend_mask[31] = 1'b0;
  end
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Testbench for regfile_wr_arbiter: table-driven directed vectors plus a
// hand-written reset-in-flight sequence.
module tb_regfile_wr_arbiter;

  logic        clk;
  logic        reset;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_addr;
  logic [63:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [63:0] b_data;
  logic        we3;
  logic [4:0]  wa3;
  logic [63:0] wd3;
  logic [2:0]  b_count;
`ifdef REGARB_PENDMASK_EN
  logic [31:0] pend_mask;
`endif

  int checks = 0;
  int errors = 0;

  regfile_wr_arbiter #(
    .DATA_W(64), .ADDR_W(5), .FIFO_DEPTH(4), .STARVE_MAX(3)
  ) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .we3(we3), .wa3(wa3), .wd3(wd3), .b_count(b_count)
`ifdef REGARB_PENDMASK_EN
    , .pend_mask(pend_mask)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [63:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [63:0] bd;
    logic        ear;   // a_ready before the edge
    logic        ebr;   // b_ready before the edge
    logic        ewe;   // we3 after the edge
    logic [4:0]  ewa;
    logic [63:0] ewd;
    logic [2:0]  ecnt;  // b_count after the edge
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic av, logic [4:0] aa, logic [63:0] ad,
                              logic bv, logic [4:0] ba, logic [63:0] bd,
                              logic ear, logic ebr, logic ewe, logic [4:0] ewa,
                              logic [63:0] ewd, logic [2:0] ecnt);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
    v.ear = ear; v.ebr = ebr; v.ewe = ewe; v.ewa = ewa; v.ewd = ewd;
    v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector at the falling edge, check readies mid-cycle, then
  // check the registered outputs just after the rising edge.
  task automatic step(input vec_t v, input int idx);
    string tag;
    @(negedge clk);
    a_valid = v.av; a_addr = v.aa; a_data = v.ad;
    b_valid = v.bv; b_addr = v.ba; b_data = v.bd;
    #1;
    tag = $sformatf("v%0d", idx);
    chk({tag, ".a_ready"}, {63'd0, a_ready}, {63'd0, v.ear});
    chk({tag, ".b_ready"}, {63'd0, b_ready}, {63'd0, v.ebr});
    @(posedge clk);
    #1;
    chk({tag, ".we3"},     {63'd0, we3},     {63'd0, v.ewe});
    chk({tag, ".wa3"},     {59'd0, wa3},     {59'd0, v.ewa});
    chk({tag, ".wd3"},     wd3,              v.ewd);
    chk({tag, ".b_count"}, {61'd0, b_count}, {61'd0, v.ecnt});
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    // A alone, then one idle cycle (wa3/wd3 hold)
    vecs.push_back(mk(1, 5, ONES, 0, 0, 0,        1, 1, 1, 5, ONES, 0));
    vecs.push_back(mk(0, 0, 0,    0, 0, 0,        1, 1, 0, 5, ONES, 0));
    // B alone: not poppable in push cycle, issued the cycle after
    vecs.push_back(mk(0, 0, 0,    1, 1, 64'hfe32, 1, 1, 0, 5, ONES, 1));
    vecs.push_back(mk(0, 0, 0,    0, 0, 0,        1, 1, 1, 1, 64'hfe32, 0));
    vecs.push_back(mk(0, 0, 0,    0, 0, 0,        1, 1, 0, 1, 64'hfe32, 0));
    // Starvation: B (addr 7) waits three A issues, then is forced
    vecs.push_back(mk(1, 10, 64'hA10, 1, 7, 64'h777, 1, 1, 1, 10, 64'hA10, 1));
    vecs.push_back(mk(1, 11, 64'hA11, 0, 0, 0,       1, 1, 1, 11, 64'hA11, 1));
    vecs.push_back(mk(1, 12, 64'hA12, 0, 0, 0,       1, 1, 1, 12, 64'hA12, 1));
    vecs.push_back(mk(1, 13, 64'hA13, 0, 0, 0,       1, 1, 1, 13, 64'hA13, 1));
    vecs.push_back(mk(1, 14, 64'hA14, 0, 0, 0,       0, 1, 1, 7,  64'h777, 0));
    vecs.push_back(mk(1, 14, 64'hA14, 0, 0, 0,       1, 1, 1, 14, 64'hA14, 0));
    vecs.push_back(mk(0, 0, 0,        0, 0, 0,       1, 1, 0, 14, 64'hA14, 0));
    // Full: four back-to-back pushes under steady A traffic
    vecs.push_back(mk(1, 20, 64'h20, 1, 1, 64'hB1,   1, 1, 1, 20, 64'h20, 1));
    vecs.push_back(mk(1, 21, 64'h21, 1, 2, 64'hB2,   1, 1, 1, 21, 64'h21, 2));
    vecs.push_back(mk(1, 22, 64'h22, 1, 3, 64'hB3,   1, 1, 1, 22, 64'h22, 3));
    vecs.push_back(mk(1, 23, 64'h23, 1, 4, 64'hB4,   1, 1, 1, 23, 64'h23, 4));
    // full + forced pop: extra push (addr 9) must be refused
    vecs.push_back(mk(1, 24, 64'h24, 1, 9, 64'h99,   0, 0, 1, 1,  64'hB1, 3));
    vecs.push_back(mk(1, 24, 64'h24, 0, 0, 0,        1, 1, 1, 24, 64'h24, 3));
    vecs.push_back(mk(1, 25, 64'h25, 0, 0, 0,        1, 1, 1, 25, 64'h25, 3));
    vecs.push_back(mk(1, 26, 64'h26, 0, 0, 0,        1, 1, 1, 26, 64'h26, 3));
    vecs.push_back(mk(1, 27, 64'h27, 0, 0, 0,        0, 1, 1, 2,  64'hB2, 2));
    vecs.push_back(mk(0, 0, 0,       0, 0, 0,        1, 1, 1, 3,  64'hB3, 1));
    vecs.push_back(mk(0, 0, 0,       0, 0, 0,        1, 1, 1, 4,  64'hB4, 0));
    vecs.push_back(mk(0, 0, 0,       0, 0, 0,        1, 1, 0, 4,  64'hB4, 0));
    // XZR via A and via B: handshake/pop completes, we3 stays low
    vecs.push_back(mk(1, 31, 64'h6e6e6e, 0, 0, 0,    1, 1, 0, 31, 64'h6e6e6e, 0));
    vecs.push_back(mk(0, 0, 0,       0, 0, 0,        1, 1, 0, 31, 64'h6e6e6e, 0));
    vecs.push_back(mk(0, 0, 0,       1, 31, 64'h55,  1, 1, 0, 31, 64'h6e6e6e, 1));
    vecs.push_back(mk(0, 0, 0,       0, 0, 0,        1, 1, 0, 31, 64'h55, 0));
    // Build up b_count=2 with we3=1 ahead of the reset sequence
    vecs.push_back(mk(1, 9, 64'h99,   1, 8, 64'h88,  1, 1, 1, 9,  64'h99, 1));
    vecs.push_back(mk(1, 10, 64'h1010, 1, 6, 64'h66, 1, 1, 1, 10, 64'h1010, 2));

    reset = 1'b1;
    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    #12;
    chk("rst.we3",     {63'd0, we3},     64'd0);
    chk("rst.wa3",     {59'd0, wa3},     64'd0);
    chk("rst.wd3",     wd3,              64'd0);
    chk("rst.b_count", {61'd0, b_count}, 64'd0);
    chk("rst.a_ready", {63'd0, a_ready}, 64'd1);
    chk("rst.b_ready", {63'd0, b_ready}, 64'd1);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i], i);
`ifdef REGARB_PENDMASK_EN
      if (vecs[i].aa == 5'd31 && vecs[i].av) begin
        #1;
        chk("xzr.pend31", {63'd0, pend_mask[31]}, 64'd0);
      end
`endif
    end

    // Reset asserted between edges while b_count=2 and we3=1
    chk("pre.we3",     {63'd0, we3},     64'd1);
    chk("pre.b_count", {61'd0, b_count}, 64'd2);
    a_valid = 0; b_valid = 0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst.we3",     {63'd0, we3},     64'd0);
    chk("arst.wa3",     {59'd0, wa3},     64'd0);
    chk("arst.wd3",     wd3,              64'd0);
    chk("arst.b_count", {61'd0, b_count}, 64'd0);
    chk("arst.b_ready", {63'd0, b_ready}, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    // No stale queued writes after release
    for (int k = 0; k < 3; k++) begin
      step(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 64'd0, 0), 100 + k);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
